// File: rtl/sram_controller_pkg.sv
// Shared SRAM bus configuration used by the controller, the SRAM model and the memory-map decode.
// Holds the bus geometry defaults, the controller state encoding and the byte-address to word-index helper.
package sram_controller_pkg;

    localparam int unsigned CFG_SRAM_ADDR_W = 17;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned CFG_ADDR_BASE   = 1024;
    localparam int unsigned CFG_WAIT_CYCLES = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Word offset from the window base; callers truncate to the SRAM address width, so it wraps.
    function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage initiator for a single-port 32-bit SRAM: one read or write per request, WAIT_CYCLES access cycles.
// Latency WAIT_CYCLES+2 cycles per access; backpressure by holding READY low from request until DONE.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = CFG_ADDR_BASE,
    parameter int unsigned WAIT_CYCLES = CFG_WAIT_CYCLES,
    parameter int unsigned SRAM_ADDR_W = CFG_SRAM_ADDR_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WR_EN,
    input  logic                   RD_EN,
    input  logic [31:0]            ADDR,
    input  logic [DATA_W-1:0]      WR_DATA,
    output logic [DATA_W-1:0]      RD_DATA,
    output logic                   READY,
    output logic                   SRAM_WE_N,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0]      SRAM_DQ
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   wr_q, wr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   drive_dq;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            sram_addr_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            sram_addr_q <= sram_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        sram_addr_d = sram_addr_q;
        rd_data_d   = rd_data_q;
        READY       = 1'b0;
        drive_dq    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // READY falls in the request cycle itself so the pipeline freeze starts at once.
                READY = ~WR_EN & ~RD_EN;
                if (WR_EN | RD_EN) begin
                    wr_d        = WR_EN;
                    wdata_d     = WR_DATA;
                    sram_addr_d = SRAM_ADDR_W'(word_offset(ADDR, ADDR_BASE));
                    count_d     = '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                drive_dq = wr_q;
                if (count_q == CNT_LAST) begin
                    count_d = '0;
                    state_d = ST_DONE;
                    if (!wr_q) begin
                        rd_data_d = SRAM_DQ;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                READY   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign SRAM_WE_N = ~drive_dq;
    assign SRAM_DQ   = drive_dq ? wdata_q : {DATA_W{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign RD_DATA   = rd_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller against an SRAM model with a 30 ns read delay (Tclk = 20 ns).
// The driver pushes expectations from a word-array reference; an independent monitor checks each completion.
module tb_sram_controller;

    localparam int unsigned BASE  = 1024;
    localparam int unsigned WAITC = 5;
    localparam int unsigned AW    = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [31:0]   addr, wr_data;
    logic [31:0]   rd_data;
    logic          ready, we_n;
    logic [AW-1:0] sram_addr;
    wire  [31:0]   sram_dq;

    always #10 clk = ~clk;

    sram_controller #(
        .ADDR_BASE  (BASE),
        .WAIT_CYCLES(WAITC),
        .SRAM_ADDR_W(AW)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .WR_EN    (wr_en),
        .RD_EN    (rd_en),
        .ADDR     (addr),
        .WR_DATA  (wr_data),
        .RD_DATA  (rd_data),
        .READY    (ready),
        .SRAM_WE_N(we_n),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ  (sram_dq)
    );

    // ---------------- SRAM model: output enable tied on, drives whenever WE_N is high ----------------
    logic [31:0] sram_mem [int];
    logic [31:0] sram_out;
    int          sram_wr_cnt = 0;

    assign sram_dq = we_n ? sram_out : 32'bz;

    always @(posedge clk) begin
        if (we_n == 1'b0) begin
            sram_mem[int'(sram_addr)] = sram_dq;
            sram_wr_cnt++;
        end
    end

    initial begin : sram_read_delay
        logic [AW-1:0] pa;
        logic          pw;
        int            pcnt;
        longint        t_chg;
        pa = '0; pw = 1'b1; pcnt = 0; t_chg = 0;
        sram_out = 32'hA5A5_A5A5;
        forever begin
            #1;
            if (sram_addr !== pa || we_n !== pw || sram_wr_cnt != pcnt) begin
                t_chg = longint'($time);
                pa    = sram_addr;
                pw    = we_n;
                pcnt  = sram_wr_cnt;
            end
            if (longint'($time) - t_chg >= 30)
                sram_out = sram_mem.exists(int'(pa)) ? sram_mem[int'(pa)] : 32'h0;
            else
                sram_out = 32'hA5A5_A5A5;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        bit            is_wr;
        logic [AW-1:0] idx;
        logic [31:0]   rd;
        logic [31:0]   wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd = 32'h0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] idx_of(input logic [31:0] a);
        return AW'(((a - 32'(BASE)) / 32'd4) % 32'd131072);
    endfunction

    function automatic logic [31:0] ref_word(input logic [AW-1:0] i);
        return ref_mem.exists(int'(i)) ? ref_mem[int'(i)] : 32'h0;
    endfunction

    // Issues one request, holds it until READY is seen, returns the cycles spent including the READY cycle.
    task automatic do_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                          input bit scramble, output int cyc);
        exp_t e;
        e.is_wr = w;
        e.idx   = idx_of(a);
        e.wdata = d;
        if (w) ref_mem[int'(e.idx)] = d;
        else if (r) ref_rd = ref_word(e.idx);
        e.rd = ref_rd;
        exp_q.push_back(e);
        @(negedge clk);
        wr_en = w; rd_en = r; addr = a; wr_data = d;
        cyc = 1;
        #1;
        while (!ready && cyc < 50) begin
            @(negedge clk);
            if (scramble) begin
                addr    = $urandom;
                wr_data = $urandom;
            end
            #1;
            cyc++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got READY=0 for %0d cycles expected completion", cyc);
        end
    endtask

    task automatic do_idle(input int n);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; addr = $urandom; wr_data = $urandom;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int   busy;
        int   wec;
        bit   bus_ok;
        exp_t e;
        busy = 0; wec = 0; bus_ok = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                busy = 0; wec = 0; bus_ok = 1'b1;
                continue;
            end
            if (!ready) begin
                busy++;
                if (!we_n) begin
                    wec++;
                    if (exp_q.size() > 0 && sram_dq !== exp_q[0].wdata) bus_ok = 1'b0;
                end
            end else if (busy > 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got completion expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("busy_cycles", 32'(busy), 32'(WAITC + 1));
                    check("we_low_cycles", 32'(wec), e.is_wr ? 32'(WAITC) : 32'd0);
                    check("sram_addr", 32'(sram_addr), 32'(e.idx));
                    check("rd_data", rd_data, e.rd);
                    check("done_we_n", 32'(we_n), 32'd1);
                    if (e.is_wr) check("write_bus_data", 32'(bus_ok), 32'd1);
                end
                busy = 0; wec = 0; bus_ok = 1'b1;
            end else begin
                check("idle_we_n", 32'(we_n), 32'd1);
                check("idle_bus_released", sram_dq, sram_out);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish within time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        int          c1, c2;
        int          op;
        logic [31:0] a;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_we_n", 32'(we_n), 32'd1);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_sram_addr", 32'(sram_addr), 32'h0);
        check("reset_bus_released", sram_dq, sram_out);
        do_idle(2);

        do_req(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 1'b0, c1);
        check("mem1_after_write", sram_mem.exists(1) ? sram_mem[1] : 32'h0, 32'hDEAD_BEEF);
        do_idle(1);
        do_req(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, c1);
        check("read_back_cycles", 32'(c1), 32'(WAITC + 2));
        do_idle(1);

        do_req(1'b1, 1'b0, 32'd1024, 32'd5, 1'b0, c1);
        do_req(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, c2);
        check("back_to_back_cycles", 32'(c1 + c2), 32'd14);

        do_req(1'b1, 1'b1, 32'd1032, 32'd7, 1'b0, c1);
        check("both_en_mem2", sram_mem.exists(2) ? sram_mem[2] : 32'h0, 32'd7);

        // Reset during the fourth access cycle of a write, request withdrawn with it.
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; addr = 32'd1036; wr_data = 32'h1234_5678;
        ref_mem[3] = 32'h1234_5678;
        repeat (4) @(negedge clk);
        #1;
        check("abort_we_n_before_reset", 32'(we_n), 32'd0);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_rd = 32'h0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_we_n", 32'(we_n), 32'd1);
        check("abort_rd_data", rd_data, 32'h0);
        check("abort_sram_addr", 32'(sram_addr), 32'h0);
        check("abort_bus_released", sram_dq, sram_out);
        do_idle(1);
        do_req(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, c1);
        do_req(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0, c1);

        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 8) a = 32'(BASE) + 32'd4 * $urandom_range(0, 31);
            else                          a = $urandom & 32'hFFFF_FFFC;
            do_req(op <= 1 || op == 3, op >= 2, a, $urandom, 1'b1, c1);
            if ($urandom_range(0, 2) != 0) do_idle(int'($urandom_range(0, 2)));
        end

        do_idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
